// File: rtl/signed_mul_ctrl.sv
// Sequential signed multiplier for the ALU operand path.
// Operands go to sign/magnitude form, run a BITS-step shift-add, and the sign is restored on the product.
module signed_mul_ctrl #(
    parameter int unsigned BITS = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                START,
    input  logic [BITS-1:0]     A,
    input  logic [BITS-1:0]     B,
    output logic                BUSY,
    output logic                DONE,
    output logic [2*BITS-1:0]   P,
    output logic                ZERO,
    output logic                NEG,
    output logic                MIN
);

    localparam int unsigned PW = 2 * BITS;
    localparam int unsigned CW = $clog2(BITS);
    localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [BITS-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sgn_q, sgn_d;
    logic            min_r_q, min_r_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   p_q, p_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;
    logic            min_q, min_d;

    logic [BITS-1:0] mag_a, mag_b;
    logic [PW-1:0]   fix_res;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        min_r_d  = min_r_q;
        p_d      = p_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        min_d    = min_q;

        // Most-negative operand maps to 2^(BITS-1), which is exact as an unsigned magnitude.
        mag_a   = a_q[BITS-1] ? (~a_q + BITS'(1)) : a_q;
        mag_b   = b_q[BITS-1] ? (~b_q + BITS'(1)) : b_q;
        fix_res = sgn_q ? (~acc_q + PW'(1)) : acc_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                mcand_d  = {{BITS{1'b0}}, mag_a};
                mplier_d = mag_b;
                sgn_d    = a_q[BITS-1] ^ b_q[BITS-1];
                min_r_d  = (a_q == MOST_NEG) || (b_q == MOST_NEG);
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = S_MUL;
            end
            S_MUL: begin
                // Iteration i consumes magB[i] and adds magA << i.
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(BITS - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                p_d     = fix_res;
                zero_d  = (fix_res == '0);
                neg_d   = fix_res[PW-1];
                min_d   = min_r_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_MUL) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            min_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            p_q      <= '0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
            min_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            min_r_q  <= min_r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            p_q      <= p_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            min_q    <= min_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign P    = p_q;
    assign ZERO = zero_q;
    assign NEG  = neg_q;
    assign MIN  = min_q;

endmodule

// File: tb/tb_signed_mul_ctrl.sv
// Bench for signed_mul_ctrl: directed table, back-to-back, reset abort, exhaustive and random
// operand pairs against a plain signed-arithmetic reference.
module tb_signed_mul_ctrl;

    localparam int unsigned BITS = 4;
    localparam int unsigned PW   = 2 * BITS;
    localparam int unsigned LAT  = BITS + 2;

    logic            CLK;
    logic            nRST;
    logic            START;
    logic [BITS-1:0] A, B;
    logic            BUSY, DONE, ZERO, NEG, MIN;
    logic [PW-1:0]   P;

    int n_vec;
    int n_bad;

    signed_mul_ctrl #(.BITS(BITS)) dut (
        .CLK(CLK), .nRST(nRST), .START(START), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .P(P), .ZERO(ZERO), .NEG(NEG), .MIN(MIN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

    typedef struct {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [PW-1:0]   p;
        logic            zero;
        logic            neg;
        logic            min;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: ordinary signed integer product of the two's-complement operands.
    task automatic model(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         output logic [PW-1:0] p, output logic z, output logic n, output logic m);
        int sa, sb, prod;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        prod = sa * sb;
        p    = PW'(prod);
        z    = (prod == 0);
        n    = (prod < 0);
        m    = (sa == -(2 ** (BITS - 1))) || (sb == -(2 ** (BITS - 1)));
    endtask

    // Issue one START from IDLE or DONE, then check latency, BUSY length and results.
    task automatic run_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input logic [PW-1:0] ep, input logic ez, input logic en,
                          input logic em, input string tag);
        int n, busy_n;
        A = a; B = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        A = BITS'($urandom);
        B = BITS'($urandom);
        busy_n = BUSY ? 1 : 0;
        n = 0;
        while (!DONE && n < 20) begin
            @(posedge CLK); #1;
            n++;
            if (!DONE && BUSY) busy_n++;
            if (!DONE) begin
                A = BITS'($urandom);
                B = BITS'($urandom);
            end
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(LAT));
        check({tag, "_P"}, 32'(P), 32'(ep));
        check({tag, "_ZERO"}, 32'(ZERO), 32'(ez));
        check({tag, "_NEG"}, 32'(NEG), 32'(en));
        check({tag, "_MIN"}, 32'(MIN), 32'(em));
        check({tag, "_BUSY_at_done"}, 32'(BUSY), 32'(0));
    endtask

    vec_t tbl[7];

    initial begin
        logic [PW-1:0] ep;
        logic ez, en, em;
        int gap, ndone;

        n_vec = 0; n_bad = 0;
        tbl[0] = '{4'h3, 4'hE, 8'hFA, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'h8, 4'h8, 8'h40, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{4'h8, 4'h7, 8'hC8, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{4'h0, 4'hB, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{4'hF, 4'hF, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{4'h5, 4'hD, 8'hF1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{4'h2, 4'h3, 8'h06, 1'b0, 1'b0, 1'b0};

        nRST = 1'b0; START = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_BUSY", 32'(BUSY), 32'(0));
        check("rst_DONE", 32'(DONE), 32'(0));
        check("rst_P", 32'(P), 32'(0));
        check("rst_ZERO", 32'(ZERO), 32'(1));
        check("rst_NEG", 32'(NEG), 32'(0));
        check("rst_MIN", 32'(MIN), 32'(0));
        #3 nRST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].zero, tbl[i].neg, tbl[i].min, "table");
            @(posedge CLK); #1;
        end

        // Result must hold in IDLE after the DONE pulse.
        run_op(4'h3, 4'hE, 8'hFA, 1'b0, 1'b1, 1'b0, "hold");
        repeat (3) @(posedge CLK);
        #1;
        check("hold_DONE_low", 32'(DONE), 32'(0));
        check("hold_P", 32'(P), 32'(8'hFA));
        check("hold_NEG", 32'(NEG), 32'(1));

        // START held high; operands and START scrambled while busy.
        A = 4'h2; B = 4'h3; START = 1'b1;
        @(posedge CLK); #1;
        A = BITS'($urandom); B = BITS'($urandom); START = 1'($urandom);
        gap = 0; ndone = 0;
        for (int c = 0; c < 40 && ndone < 3; c++) begin
            @(posedge CLK); #1;
            gap++;
            if (DONE) begin
                check("b2b_gap", 32'(gap), (ndone == 0) ? 32'(LAT) : 32'(LAT + 1));
                check("b2b_P", 32'(P), 32'(8'h06));
                ndone++;
                gap = 0;
                A = 4'h2; B = 4'h3;
                START = (ndone < 3);
            end else begin
                A = BITS'($urandom); B = BITS'($urandom); START = 1'($urandom);
            end
        end
        check("b2b_count", 32'(ndone), 32'(3));
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset in the middle of MUL abandons the operation.
        run_op(4'h8, 4'h7, 8'hC8, 1'b0, 1'b1, 1'b1, "pre_abort");
        @(posedge CLK); #1;
        A = 4'h8; B = 4'h7; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("abort_BUSY", 32'(BUSY), 32'(0));
        check("abort_DONE", 32'(DONE), 32'(0));
        check("abort_P", 32'(P), 32'(0));
        check("abort_ZERO", 32'(ZERO), 32'(1));
        check("abort_NEG", 32'(NEG), 32'(0));
        check("abort_MIN", 32'(MIN), 32'(0));
        @(posedge CLK); #3;
        nRST = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(posedge CLK); #1;
                if (DONE || BUSY) seen++;
            end
            check("abort_no_done", 32'(seen), 32'(0));
        end
        run_op(4'h5, 4'hD, 8'hF1, 1'b0, 1'b1, 1'b0, "post_abort");
        @(posedge CLK); #1;

        // Every operand pair.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                model(BITS'(a), BITS'(b), ep, ez, en, em);
                run_op(BITS'(a), BITS'(b), ep, ez, en, em, "sweep");
            end
        end

        // Random operands with random idle gaps, including back-to-back from DONE.
        for (int r = 0; r < 40; r++) begin
            logic [BITS-1:0] ra, rb;
            ra = BITS'($urandom);
            rb = BITS'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK); #1;
            end
            model(ra, rb, ep, ez, en, em);
            run_op(ra, rb, ep, ez, en, em, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_mul_ctrl.md
Name: signed_mul_ctrl

Overview:
Sequential controller for signed two's-complement multiplication on the ALU operand path. It converts each operand to sign/magnitude form: magnitude is BITS-bit unsigned, sign is the operand MSB. It then runs a BITS-step shift-add over the magnitudes and restores the sign on the 2*BITS-bit result. Results are published with ZERO/NEG/MIN flags and a one-cycle DONE pulse for the ALU sequencer.

Parameters:
BITS, 4, operand width in bits (two's complement, >= 3); product width is 2*BITS

Ports:
CLK  in  1  rising-edge clock
nRST  in  1  asynchronous active-low reset
START  in  1  request; sampled only in IDLE or DONE state
A  in  BITS  multiplicand, two's complement
B  in  BITS  multiplier, two's complement
BUSY  out  1  high in LOAD, MUL, FIX states
DONE  out  1  one-cycle pulse; P and flags valid
P  out  2*BITS  signed product, held until next FIX
ZERO  out  1  P == 0
NEG  out  1  P[2*BITS-1]
MIN  out  1  A or B was most-negative value (1 followed by BITS-1 zeros)

Behaviour:
- States: IDLE, LOAD, MUL, FIX, DONE (binary-encoded).
- Reset (nRST low, async): state=IDLE; BUSY=0, DONE=0, P=0, ZERO=1, NEG=0, MIN=0; internal registers cleared. Reset mid-operation abandons the operation; no DONE is produced.
- IDLE: START=1 -> LOAD; else stay. A and B are captured into operand registers on this edge.
- LOAD (1 cycle):
  - magA = A[MSB] ? -A : A, computed on BITS bits unsigned; the most-negative value maps to 2^(BITS-1), which is exact.
  - magB is computed the same way.
  - sgn = A[MSB] ^ B[MSB]; min_r = (A==most-neg) | (B==most-neg).
  - acc (2*BITS bits) = 0; cnt = 0.
  - Next state: MUL.
- MUL (exactly BITS cycles, no early exit on zero operands):
  - Iteration i: if magB[i], acc += magA << i (2*BITS-bit add, no overflow possible).
  - cnt increments each iteration; after iteration BITS-1 -> FIX.
- FIX (1 cycle):
  - P = sgn ? (~acc + 1) : acc, truncated to 2*BITS bits.
  - ZERO = (result == 0); NEG = result MSB; MIN = min_r. All outputs registered on this edge.
  - -0 case: sgn=1 with acc=0 gives P=0, NEG=0, ZERO=1.
  - Next state: DONE.
- DONE (1 cycle): DONE=1. START=1 -> LOAD, accepting new A/B for back-to-back operation; else IDLE.
- Latency: START sampled on edge e0. DONE is high during the cycle after edge e0+BITS+2. Throughput is one product per BITS+3 cycles back-to-back.
- START in LOAD/MUL/FIX is ignored; A/B changes during BUSY have no effect.
- Range: worst case (-2^(BITS-1))^2 = 2^(2*BITS-2), which fits in signed 2*BITS. No overflow flag is needed.
- P/ZERO/NEG/MIN change only on the FIX edge or on reset.

Test Plan:
- BITS=4, A=3, B=-2 (4'hE), START one cycle -> DONE pulse 6 edges after start edge; P=8'hFA, NEG=1, ZERO=0, MIN=0; BUSY high for exactly 6 cycles (LOAD + 4 MUL + FIX).
- A=-8, B=-8 -> P=8'h40 (64), NEG=0, MIN=1. Then A=-8, B=7 -> P=8'hC8 (-56), NEG=1, MIN=1.
- A=0, B=-5 -> P=8'h00, ZERO=1, NEG=0 (no negative zero). Then A=-1, B=-1 -> P=8'h01.
- START held high continuously with A=2, B=3 -> DONE every 7 cycles, P=8'h06 each time. Toggling A/B and START during BUSY does not alter the result or timing.
- nRST asserted during MUL (after iteration 2) -> all outputs return to reset values immediately (async) with no DONE. After release, a new START with A=5, B=-3 -> P=8'hF1.
- Exhaustive sweep of all 256 A/B pairs for BITS=4 against a signed reference model; P, ZERO, NEG and MIN must match on every DONE.
